// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle for the execute-stage ALU.
// The request side (valid_i, ctrl_i, src1_i, src2_i, shamt_i) comes from the
// decode/issue logic. The response side (result_o, branch_o, valid_o, busy_o)
// goes to the EX/MEM register and branch resolution.
// Optional: ALU_EXEC_OVF_EN adds overflow_o to the response side.
interface alu_exec_unit_if;
  logic        valid_i;
  logic [4:0]  ctrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [4:0]  shamt_i;
  logic [31:0] result_o;
  logic        branch_o;
  logic        valid_o;
  logic        busy_o;
`ifdef ALU_EXEC_OVF_EN
  logic        overflow_o;

  modport master (
    output valid_i, ctrl_i, src1_i, src2_i, shamt_i,
    input  result_o, branch_o, valid_o, busy_o, overflow_o
  );

  modport slave (
    input  valid_i, ctrl_i, src1_i, src2_i, shamt_i,
    output result_o, branch_o, valid_o, busy_o, overflow_o
  );
`else
  modport master (
    output valid_i, ctrl_i, src1_i, src2_i, shamt_i,
    input  result_o, branch_o, valid_o, busy_o
  );

  modport slave (
    input  valid_i, ctrl_i, src1_i, src2_i, shamt_i,
    output result_o, branch_o, valid_o, busy_o
  );
`endif
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU.
// Single-cycle ops register their result on the accepting edge. Code 16 (mult)
// runs a shift-add sequence of MUL_CYCLES iterations, and busy_o stalls upstream
// while it runs.
// Optional: define ALU_EXEC_OVF_EN to add a registered signed-overflow flag
// (overflow_o) for add/addi/sub.
module alu_exec_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  alu_exec_unit_if.slave bus
);

  localparam logic [4:0] CTRL_MUL = 5'd16;
  localparam logic [4:0] CNT_LAST = 5'(MUL_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             branch_q, branch_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_sum_s;
  logic [WIDTH:0]   single_s;
`ifdef ALU_EXEC_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single-cycle operation: returns {branch, result}. Multiply is handled by
  // the sequencer, so code 16 never reaches this path.
  function automatic logic [32:0] alu_single(
    input logic [4:0]  ctrl,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  sh
  );
    logic [31:0] r;
    logic        br;
    r  = 32'd0;
    br = 1'b0;
    case (ctrl)
      5'd0, 5'd1, 5'd13, 5'd14: r = a + b;
      5'd2:                     r = a - b;
      5'd3:                     r = a & b;
      5'd4:                     r = a | b;
      5'd5, 5'd6:               r = {31'd0, ($signed(a) < $signed(b))};
      5'd7: begin
        r  = a - b;
        br = (a == b);
      end
      5'd8: begin
        r  = a - b;
        br = (a != b);
      end
      5'd9:                     r = a | {16'd0, b[15:0]};
      5'd10:                    r = {b[15:0], 16'd0};
      5'd11:                    r = b >> sh;
      5'd12:                    r = b >> a[4:0];
      5'd15: begin
        r  = 32'd0;
        br = 1'b0;
      end
      5'd17:                    br = ~a[31];
      5'd18:                    br = ($signed(a) < $signed(b));
      default: begin
        r  = 32'd0;
        br = 1'b0;
      end
    endcase
    return {br, r};
  endfunction

`ifdef ALU_EXEC_OVF_EN
  // Signed overflow for add/addi (same-sign operands, result sign flips) and
  // sub (operand signs differ, result sign differs from A).
  function automatic logic ovf_calc(
    input logic [4:0]  ctrl,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] sum;
    logic [31:0] diff;
    logic        o;
    sum  = a + b;
    diff = a - b;
    case (ctrl)
      5'd0, 5'd1: o = (a[31] == b[31]) && (sum[31] != a[31]);
      5'd2:       o = (a[31] != b[31]) && (diff[31] != a[31]);
      default:    o = 1'b0;
    endcase
    return o;
  endfunction
`endif

  // Next-state and datapath: accept in IDLE, iterate shift-add in MUL.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    result_d  = result_q;
    branch_d  = branch_q;
    valid_d   = 1'b0;
`ifdef ALU_EXEC_OVF_EN
    ovf_d     = ovf_q;
`endif
    acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
    single_s  = alu_single(bus.ctrl_i, bus.src1_i, bus.src2_i, bus.shamt_i);

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          if (bus.ctrl_i == CTRL_MUL) begin
            mcand_d  = bus.src1_i;
            mplier_d = bus.src2_i;
            acc_d    = {WIDTH{1'b0}};
            cnt_d    = 5'd0;
            state_d  = MUL;
          end else begin
            result_d = single_s[31:0];
            branch_d = single_s[32];
            valid_d  = 1'b1;
`ifdef ALU_EXEC_OVF_EN
            ovf_d    = ovf_calc(bus.ctrl_i, bus.src1_i, bus.src2_i);
`endif
            state_d  = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d    = acc_sum_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          // Last iteration: the sum formed this cycle is the product.
          result_d = acc_sum_s;
          branch_d = 1'b0;
          valid_d  = 1'b1;
`ifdef ALU_EXEC_OVF_EN
          ovf_d    = 1'b0;
`endif
          cnt_d    = 5'd0;
          state_d  = IDLE;
        end else begin
          state_d = MUL;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase

    busy_d = (state_d == MUL);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      branch_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ALU_EXEC_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      branch_q <= branch_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef ALU_EXEC_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.result_o = result_q;
  assign bus.branch_o = branch_q;
  assign bus.valid_o  = valid_q;
  assign bus.busy_o   = busy_q;
`ifdef ALU_EXEC_OVF_EN
  assign bus.overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit. Stimulus pushes the
// expected response; a negedge monitor pops and compares on every valid_o.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_exec_unit_if bus ();

  alu_exec_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] exp_res_q[$];
  logic        exp_br_q[$];
  logic        exp_ovf_q[$];
  string       exp_name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic idle();
    bus.valid_i = 1'b0;
    bus.ctrl_i  = 5'd0;
    bus.src1_i  = 32'd0;
    bus.src2_i  = 32'd0;
    bus.shamt_i = 5'd0;
  endtask

  // Drive one request for one edge; push its expected response when scored.
  task automatic issue(input string name, input logic [4:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                       input logic eb, input logic eo, input bit scored);
    bus.valid_i = 1'b1;
    bus.ctrl_i  = ctrl;
    bus.src1_i  = a;
    bus.src2_i  = b;
    bus.shamt_i = sh;
    if (scored) begin
      exp_name_q.push_back(name);
      exp_res_q.push_back(er);
      exp_br_q.push_back(eb);
      exp_ovf_q.push_back(eo);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_valid: got valid_o=1 result=%h, required no output", bus.result_o);
      end else begin
        string       n;
        logic [31:0] er;
        logic        eb;
        logic        eo;
        n  = exp_name_q.pop_front();
        er = exp_res_q.pop_front();
        eb = exp_br_q.pop_front();
        eo = exp_ovf_q.pop_front();
        check({n, "_result"}, bus.result_o, er);
        check({n, "_branch"}, {31'd0, bus.branch_o}, {31'd0, eb});
`ifdef ALU_EXEC_OVF_EN
        check({n, "_overflow"}, {31'd0, bus.overflow_o}, {31'd0, eo});
`else
        if (eo !== eo) $display("unreachable");
`endif
      end
    end
  end

  initial begin
    int cyc;
    int busy_n;
    int valid_n;
    bit done;

    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", bus.result_o, 32'd0);
    check("reset_branch", {31'd0, bus.branch_o}, 32'd0);
    check("reset_valid",  {31'd0, bus.valid_o},  32'd0);
    check("reset_busy",   {31'd0, bus.busy_o},   32'd0);
`ifdef ALU_EXEC_OVF_EN
    check("reset_overflow", {31'd0, bus.overflow_o}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops.
    issue("b2b_add", 5'd0, 32'd5, 32'd3, 5'd0, 32'd8, 1'b0, 1'b0, 1'b1);
    issue("b2b_sub", 5'd2, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
    issue("b2b_slt", 5'd5, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0, 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Reset 10 cycles into a multiply: aborts with no later output.
    issue("abort_mul", 5'd16, 32'd7, 32'd9, 5'd0, 32'd63, 1'b0, 1'b0, 1'b0);
    idle();
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_result", bus.result_o, 32'd0);
    check("abort_busy",   {31'd0, bus.busy_o},  32'd0);
    check("abort_valid",  {31'd0, bus.valid_o}, 32'd0);
    rst_n = 1'b1;
    valid_n = 0;
    busy_n  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) valid_n++;
      if (bus.busy_o === 1'b1) busy_n++;
    end
    check("abort_no_valid", 32'(valid_n), 32'd0);
    check("abort_no_busy",  32'(busy_n),  32'd0);
    @(posedge clk);
    #1;

    // Multiply -1 * 6 with ignored requests while busy.
    issue("mult", 5'd16, 32'hFFFFFFFF, 32'd6, 5'd0, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b1);
    idle();
    cyc    = 0;
    busy_n = 0;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.valid_o === 1'b1) begin
        done = 1'b1;
        check("mul_busy_at_valid", {31'd0, bus.busy_o}, 32'd0);
      end else if (bus.busy_o === 1'b1) begin
        busy_n++;
      end
      if (cyc == 5) begin
        bus.valid_i = 1'b1;
        bus.ctrl_i  = 5'd0;
        bus.src1_i  = 32'd1;
        bus.src2_i  = 32'd1;
      end
      if (cyc == 7) idle();
    end
    check("mul_latency",     32'(cyc),    32'd33);
    check("mul_busy_cycles", 32'(busy_n), 32'd32);
    @(posedge clk);
    #1;

    // Branches.
    issue("beq",  5'd7,  32'h10, 32'h10, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    issue("bne",  5'd8,  32'h10, 32'h10, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    issue("bgez_neg", 5'd17, 32'h80000000, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    issue("bgez_pos", 5'd17, 32'd5, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    issue("blt",  5'd18, 32'hFFFFFFFE, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    issue("j",    5'd15, 32'h1234, 32'h5678, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Shifts, immediates, logic, address, undefined code.
    issue("srl",  5'd11, 32'd0, 32'h80000000, 5'd31, 32'd1, 1'b0, 1'b0, 1'b1);
    issue("srlv", 5'd12, 32'd4, 32'hF0, 5'd0, 32'hF, 1'b0, 1'b0, 1'b1);
    issue("lui",  5'd10, 32'd0, 32'h1234, 5'd0, 32'h12340000, 1'b0, 1'b0, 1'b1);
    issue("ori",  5'd9,  32'hFFFF0000, 32'hFFFF00FF, 5'd0, 32'hFFFF00FF, 1'b0, 1'b0, 1'b1);
    issue("and",  5'd3,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0, 1'b1);
    issue("or",   5'd4,  32'hF0F0F0F0, 32'h0F000000, 5'd0, 32'hFFF0F0F0, 1'b0, 1'b0, 1'b1);
    issue("lw",   5'd13, 32'h1000, 32'hFFFFFFFC, 5'd0, 32'h0FFC, 1'b0, 1'b0, 1'b1);
    issue("code31", 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'd0, 1'b0, 1'b0, 1'b1);

    // Signed-overflow corners (results always checked, flag when enabled).
    issue("ovf_add", 5'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    issue("ovf_sub", 5'd2, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
    issue("noovf_add", 5'd0, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1'b0, 1'b1);
    idle();

    // Every expected response must have been seen.
    for (int i = 0; i < 10 && exp_res_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_res_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
